// File: rtl/controller_pkg.sv
// Shared definitions for the serial game-controller reader.
// Holds the poll FSM state encoding and the bit position of each button.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/shift_register.sv
// Generic serial-in/parallel-out shift register.
// LEFT=1 shifts toward the MSB; LEFT=0 inserts at the MSB and shifts right.
module shift_register #(
    parameter int WIDTH = 8,
    parameter bit LEFT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (shift_en)
            q <= LEFT ? {q[WIDTH-2:0], serial_in} : {serial_in, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/controller_reader.sv
// Polls a serial game controller: latch strobe, eight shift-clock phases,
// then publishes the captured button states with a one-cycle done pulse.
module controller_reader
    import controller_pkg::*;
#(
    parameter int HALF_TICKS = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] buttons,
    output logic       ctrl_latch,
    output logic       ctrl_pulse,
    input  logic       ctrl_data
);

    localparam int TW = $clog2(2 * HALF_TICKS);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * HALF_TICKS - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_TICKS - 1);

    state_t        state, next_state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [1:0]    sync;
    logic          sync_data;
    logic          phase_end;
    logic          shift_en;
    logic [7:0]    shift_q;
    logic [7:0]    buttons_reg;

    // Synchronizer idles high so a released controller reads as "not pressed".
    always_ff @(posedge clock) begin
        if (reset)
            sync <= 2'b11;
        else
            sync <= {sync[0], ctrl_data};
    end

    assign sync_data = sync[1];
    assign phase_end = (tick == '0);

    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    next_state = LATCH;
            end
            LATCH: begin
                if (phase_end)
                    next_state = LOW;
            end
            LOW: begin
                if (phase_end) begin
                    shift_en   = 1'b1;
                    next_state = (bit_idx == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (phase_end)
                    next_state = LOW;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so they track the state exactly
    // without decode glitches on the controller cable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            buttons_reg <= '0;
            ctrl_latch  <= 1'b0;
            ctrl_pulse  <= 1'b0;
        end else begin
            state      <= next_state;
            ctrl_latch <= (next_state == LATCH);
            ctrl_pulse <= (next_state == HIGH);

            if (next_state != state) begin
                case (next_state)
                    LATCH:     tick <= LATCH_LOAD;
                    LOW, HIGH: tick <= HALF_LOAD;
                    default:   tick <= '0;
                endcase
            end else if (!phase_end) begin
                tick <= tick - 1'b1;
            end

            if (state == LATCH)
                bit_idx <= '0;
            else if (state == HIGH && phase_end)
                bit_idx <= bit_idx + 3'd1;

            if (state == DONE)
                buttons_reg <= shift_q;
        end
    end

    shift_register #(
        .WIDTH (8),
        .LEFT  (1'b0)
    ) u_capture (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .serial_in (~sync_data),
        .q         (shift_q)
    );

    // New data is visible during the done cycle itself, then held.
    assign buttons = (state == DONE) ? shift_q : buttons_reg;

endmodule

// File: tb/tb_controller_reader.sv
// Scoreboard bench for controller_reader with a behavioural serial controller.
module tb_controller_reader;

    localparam int HT = 4;

    typedef struct {
        logic [7:0] btn;
        int         cyc;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] buttons;
    logic       ctrl_latch;
    logic       ctrl_pulse;
    logic       ctrl_data;

    int   cyc;
    int   compared;
    int   mismatched;
    int   done_seen;
    int   last_done;
    exp_t sb[$];

    logic [7:0] pressed;
    logic [7:0] cur;
    logic [3:0] idx;
    logic       pulse_d;

    int latch_cnt, overlap, run, pulse_runs, bad_runs;

    controller_reader #(.HALF_TICKS(HT)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .buttons    (buttons),
        .ctrl_latch (ctrl_latch),
        .ctrl_pulse (ctrl_pulse),
        .ctrl_data  (ctrl_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Controller model: snapshot on latch, advance one bit per shift-clock rise.
    always @(posedge clock) begin
        pulse_d <= ctrl_pulse;
        if (ctrl_latch) begin
            cur <= pressed;
            idx <= 4'd0;
        end else if (ctrl_pulse && !pulse_d && idx < 4'd8) begin
            idx <= idx + 4'd1;
        end
    end

    assign ctrl_data = (idx < 4'd8) ? ~cur[idx[2:0]] : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clearWave();
        latch_cnt  = 0;
        overlap    = 0;
        run        = 0;
        pulse_runs = 0;
        bad_runs   = 0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            clearWave();
        end else begin
            if (ctrl_latch) latch_cnt++;
            if (ctrl_latch && ctrl_pulse) overlap++;
            if (ctrl_pulse) begin
                run++;
            end else if (run != 0) begin
                pulse_runs++;
                if (run != HT) bad_runs++;
                run = 0;
            end
            if (done) begin
                done_seen++;
                last_done = cyc;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("buttons", 32'(buttons), 32'(e.btn));
                    checkOutput("done_cycle", cyc, e.cyc);
                    checkOutput("latch_cycles", latch_cnt, 2 * HT);
                    checkOutput("pulse_count", pulse_runs, 7);
                    checkOutput("pulse_width_bad", bad_runs, 0);
                    checkOutput("latch_pulse_overlap", overlap, 0);
                end
                clearWave();
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic waitDone(input int target, input int budget);
        int waited;
        waited = 0;
        while (done_seen < target && waited < budget) begin
            step(1);
            waited++;
        end
        if (done_seen < target)
            checkOutput("done_timeout", done_seen, target);
    endtask

    // Drive one start pulse; done is due 69 cycles after the start cycle.
    task automatic applyStimulus(input logic [7:0] pattern);
        exp_t e;
        pressed = pattern;
        e.btn   = pattern;
        e.cyc   = cyc + 17 * HT + 1;
        sb.push_back(e);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int target;
        int t0;
        exp_t e;
        logic [7:0] pats [4];
        pats = '{8'h11, 8'hE7, 8'hFF, 8'h24};

        cyc = 0; compared = 0; mismatched = 0; done_seen = 0; last_done = 0;
        target = 0;
        pressed = 8'h00; cur = 8'h00; idx = 4'd8; pulse_d = 1'b0;
        clearWave();
        reset = 1'b1;
        start = 1'b0;
        step(3);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_buttons", 32'(buttons), 0);
        checkOutput("reset_latch", 32'(ctrl_latch), 0);
        checkOutput("reset_pulse", 32'(ctrl_pulse), 0);
        reset = 1'b0;
        step(2);

        $display("[TB] poll with all buttons released");
        applyStimulus(8'h00);
        waitDone(++target, 200);
        step(3);

        $display("[TB] poll with A and Right pressed");
        applyStimulus(8'h81);
        waitDone(++target, 200);
        step(5);
        checkOutput("buttons_hold", 32'(buttons), 32'h81);
        checkOutput("idle_busy", 32'(busy), 0);

        $display("[TB] start pulsed while busy");
        applyStimulus(8'h5A);
        step(9);
        checkOutput("busy_mid", 32'(busy), 1);
        for (int p = 0; p < 3; p++) begin
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(19);
        end
        waitDone(++target, 200);
        step(100);
        checkOutput("single_done", done_seen, target);
        checkOutput("busy_after", 32'(busy), 0);

        $display("[TB] reset in the middle of a poll");
        t0 = cyc;
        applyStimulus(8'hC3);
        while (cyc < t0 + 30) step(1);
        reset = 1'b1;
        sb.delete();
        step(1);
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_done", 32'(done), 0);
        checkOutput("midreset_buttons", 32'(buttons), 0);
        checkOutput("midreset_latch", 32'(ctrl_latch), 0);
        checkOutput("midreset_pulse", 32'(ctrl_pulse), 0);
        reset = 1'b0;
        step(2);
        applyStimulus(8'h3C);
        waitDone(++target, 200);
        step(3);

        $display("[TB] start held for back-to-back polls");
        pressed = pats[0];
        e.btn = pats[0];
        e.cyc = cyc + 17 * HT + 1;
        sb.push_back(e);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitDone(++target, 200);
            if (k < 3) begin
                pressed = pats[k+1];
                e.btn = pats[k+1];
                e.cyc = last_done + 17 * HT + 2;
                sb.push_back(e);
            end else begin
                start = 1'b0;
            end
        end
        step(100);
        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
